// File: rtl/piso_serializer_if.sv
// Load/serial handshake bundle for piso_serializer. The producer/consumer side
// takes the master modport and the serializer takes the slave modport.
interface piso_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] P_in;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             S_out;
  logic             s_valid;
  logic             s_last;
  logic             busy;

  modport master (
    output P_in, load_valid, shift_en,
    input  load_ready, S_out, s_valid, s_last, busy
  );

  modport slave (
    input  P_in, load_valid, shift_en,
    output load_ready, S_out, s_valid, s_last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a valid/ready load and framed serial output.
// Define PISO_PARITY_EN to append one even-parity bit to every frame.
//
//   state  | meaning
//   IDLE   | no frame in progress, ready for a word
//   SHIFT  | emitting data bits, one per shift_en
//   PARITY | emitting the trailing parity bit (PISO_PARITY_EN only)
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic   clk,
  input logic   rst,
  piso_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [CW-1:0]    cnt_q;
  logic             head;
  logic             s_last;
  logic             load_ready;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par_q;
`endif

  assign sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
  assign head   = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

`ifdef PISO_PARITY_EN
  assign s_last    = (state_q == PARITY);
  assign bus.S_out = ((state_q == SHIFT) & head) | ((state_q == PARITY) & par_q);
`else
  assign s_last    = (state_q == SHIFT) && (cnt_q == '0);
  assign bus.S_out = (state_q == SHIFT) & head;
`endif

  // Ready during the last bit lets the next word follow with no gap.
  assign load_ready     = rst & ((state_q == IDLE) | (s_last & bus.shift_en));
  assign accept         = bus.load_valid & load_ready;
  assign bus.load_ready = load_ready;
  assign bus.s_valid    = (state_q != IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.s_last     = s_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (accept) begin
      state_q <= SHIFT;
      sreg_q  <= bus.P_in;
      cnt_q   <= CW'(WIDTH - 1);
`ifdef PISO_PARITY_EN
      par_q   <= ^bus.P_in;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (bus.shift_en) begin
            sreg_q <= sreg_d;
            if (cnt_q == '0) begin
`ifdef PISO_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= IDLE;
`endif
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          if (bus.shift_en) state_q <= IDLE;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (4-bit MSB-first, 4-bit LSB-first,
// 8-bit MSB-first) share the control inputs and are compared with a bit-queue model.
module tb_piso_serializer;
  typedef bit bq_t[$];

  logic clk;
  logic rst;
  logic load_valid;
  logic shift_en;

  int checks = 0;
  int passed = 0;

  piso_if #(.WIDTH(4)) if4m ();
  piso_if #(.WIDTH(4)) if4l ();
  piso_if #(.WIDTH(8)) if8m ();

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u4m (.clk(clk), .rst(rst), .bus(if4m));
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u4l (.clk(clk), .rst(rst), .bus(if4l));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u8m (.clk(clk), .rst(rst), .bus(if8m));

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Model: each instance holds the queue of frame bits still to appear on S_out.
  bq_t mq[3];
  int  mw[3] = '{4, 4, 8};
  bit  mm[3] = '{1'b1, 1'b0, 1'b1};

  function automatic bq_t frame_bits(logic [31:0] w, int width, bit msb);
    bq_t r;
    bit  par = 1'b0;
    for (int k = 0; k < width; k++) begin
      r.push_back(msb ? w[width-1-k] : w[k]);
      par ^= w[k];
    end
`ifdef PISO_PARITY_EN
    r.push_back(par);
`else
    if (par) r = r;
`endif
    return r;
  endfunction

  // {load_ready, s_valid, s_last, busy, S_out}
  function automatic logic [4:0] exp_vec(int i);
    int   sz = mq[i].size();
    logic rdy = rst && ((sz == 0) || (sz == 1 && shift_en));
    logic vld = (sz > 0);
    logic sb  = vld ? mq[i][0] : 1'b0;
    return {rdy, vld, (sz == 1), vld, sb};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    chk("u4m_out", {if4m.load_ready, if4m.s_valid, if4m.s_last, if4m.busy, if4m.S_out}, exp_vec(0));
    chk("u4l_out", {if4l.load_ready, if4l.s_valid, if4l.s_last, if4l.busy, if4l.S_out}, exp_vec(1));
    chk("u8m_out", {if8m.load_ready, if8m.s_valid, if8m.s_last, if8m.busy, if8m.S_out}, exp_vec(2));
  endtask

  task automatic model_update(bit lv, bit se, logic [7:0] p);
    for (int i = 0; i < 3; i++) begin
      logic [4:0] e = exp_vec(i);
      if (!rst) mq[i].delete();
      else begin
        if (se && mq[i].size() > 0) void'(mq[i].pop_front());
        if (lv && e[4]) mq[i] = frame_bits({24'd0, p}, mw[i], mm[i]);
      end
    end
  endtask

  // Called just after a rising edge; drives inputs, checks at the falling edge.
  task automatic step(bit lv, bit se, logic [7:0] p);
    load_valid = lv; shift_en = se;
    if4m.load_valid = lv; if4m.shift_en = se; if4m.P_in = p[3:0];
    if4l.load_valid = lv; if4l.shift_en = se; if4l.P_in = p[3:0];
    if8m.load_valid = lv; if8m.shift_en = se; if8m.P_in = p;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update(lv, se, p);
    #1;
  endtask

  task automatic pulse_reset();
    load_valid = 1'b0;
    if4m.load_valid = 1'b0; if4l.load_valid = 1'b0; if8m.load_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) mq[i].delete();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit [3:0] seq;
    rst = 1'b0;
    load_valid = 1'b0; shift_en = 1'b0;
    if4m.load_valid = 1'b0; if4m.shift_en = 1'b0; if4m.P_in = '0;
    if4l.load_valid = 1'b0; if4l.shift_en = 1'b0; if4l.P_in = '0;
    if8m.load_valid = 1'b0; if8m.shift_en = 1'b0; if8m.P_in = '0;
    #12;
    check_all();
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    // Ordering: 4'b1110 gives 1,1,1,0 MSB-first and 0,1,1,1 LSB-first.
    seq = 4'b1110;
    step(1'b1, 1'b1, 8'h0E);
    for (int k = 0; k < 4; k++) begin
      chk("msb_order", {31'd0, if4m.S_out}, {31'd0, seq[3-k]});
      chk("lsb_order", {31'd0, if4l.S_out}, {31'd0, seq[k]});
      step(1'b0, 1'b1, 8'h00);
    end
`ifndef PISO_PARITY_EN
    chk("idle_after", {31'd0, if4m.s_valid}, 32'd0);
`endif
    repeat (6) step(1'b0, 1'b1, 8'h00);

    // Stall on 8'hA5 after the 2nd bit.
    step(1'b1, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'h00);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    repeat (9) step(1'b0, 1'b1, 8'h00);

    // Back-to-back: 4'b1001 then 4'b0110 presented during the last bit.
    step(1'b1, 1'b1, 8'h09);
    repeat (3) step(1'b1, 1'b1, 8'h09);
`ifdef PISO_PARITY_EN
    step(1'b1, 1'b1, 8'h09);
`endif
    step(1'b1, 1'b1, 8'h06);
    repeat (10) step(1'b0, 1'b1, 8'h00);

    // Mid-frame reset after the 3rd bit, then a clean 8'hFF frame.
    step(1'b1, 1'b1, 8'h5A);
    repeat (3) step(1'b0, 1'b1, 8'h00);
    pulse_reset();
    step(1'b1, 1'b1, 8'hFF);
    repeat (10) step(1'b0, 1'b1, 8'h00);

    // Randomized traffic with occasional stalls and one reset.
    for (int n = 0; n < 400; n++) begin
      if (n == 217) pulse_reset();
      step(1'($urandom), $urandom_range(0, 3) != 0, 8'($urandom));
    end
    repeat (12) step(1'b0, 1'b1, 8'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, selectable bit order, shift-enable stalling and framed serial output (valid/last). It is the successor to the fixed 4-bit load/shift register in the lab datapath. It sits between a parallel word producer and a bit-serial consumer such as a UART/SPI-style transmit stage. It supports back-to-back words with no idle bit between frames.

## Interface
Parameters:
- WIDTH, 8: data word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 shifts out bit WIDTH-1 first; 0 shifts out bit 0 first.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- P_in  in  WIDTH  parallel word, sampled only on an accepted load.
- load_valid  in  1  producer offers P_in.
- load_ready  out  1  serializer can accept a word this cycle.
- shift_en  in  1  consumer advance strobe; 0 holds the current bit.
- S_out  out  1  serial data bit.
- s_valid  out  1  S_out carries a frame bit.
- s_last  out  1  S_out is the final bit of the frame.
- busy  out  1  a frame is in progress.

## Operation
- States: IDLE, SHIFT, and PARITY (PARITY exists only when the parity feature is compiled in).
- Accept: a load is accepted on a rising edge where load_valid and load_ready are both 1.
  - P_in is copied into the shift register.
  - The bit counter is set to WIDTH-1.
  - The state goes to SHIFT.
- IDLE:
  - load_ready=1, s_valid=0, S_out=0, busy=0.
  - shift_en is ignored.
- SHIFT:
  - S_out is the current head bit: reg[WIDTH-1] when MSB_FIRST=1, reg[0] when MSB_FIRST=0.
  - s_valid=1 and busy=1.
  - On an edge with shift_en=1 the register shifts toward the head and the counter decrements.
  - On an edge with shift_en=0 all state holds.
- Last bit:
  - s_last=1 when the counter is 0 and parity is compiled out, or in the PARITY state.
  - load_ready = IDLE OR (s_last AND shift_en). This is combinational and permits back-to-back frames.
- End of frame, on an edge with s_last=1 and shift_en=1:
  - if a load is accepted on that same edge, the new word is loaded and the state stays SHIFT;
  - otherwise the state goes to IDLE.
- Counter width: $clog2(WIDTH). Bits vacated by the shift are filled with 0.
- load_valid while load_ready=0 is ignored. P_in has no effect outside an accept.

## Timing
- Reset (rst=0, asynchronous):
  - state goes to IDLE; shift register and counter are cleared.
  - S_out=0, s_valid=0, s_last=0, busy=0.
  - load_ready is forced to 0 while rst=0 and is 1 in the first cycle after release.
- Reset asserted mid-frame: the frame is abandoned with no partial output, and outputs go to their reset values immediately.
- Latency: the first bit is on S_out in the cycle after the accept edge.
- Frame length: WIDTH bits, or WIDTH+1 bits with parity. With shift_en held high, a frame takes exactly WIDTH (or WIDTH+1) cycles.
- Back-to-back: the next frame's first bit appears in the cycle immediately after the previous last bit, with no gap in s_valid.
- Stall: while shift_en=0, S_out, s_valid and s_last hold indefinitely.

## Configuration
- PISO_PARITY_EN
  - Defined:
    - after the WIDTH data bits, the PARITY state emits one even-parity bit (XOR of the accepted word);
    - s_last is asserted only on the parity bit;
    - the parity value is computed at accept time and stored.
  - Undefined:
    - the PARITY state and parity register are absent;
    - s_last is asserted on data bit WIDTH-1 of the frame.

## Test plan
- Reset and ordering: WIDTH=4, MSB_FIRST=1. Hold rst=0 for 15 time units, release, load 4'b1110, hold shift_en=1.
  - S_out = 1,1,1,0 on consecutive cycles.
  - s_last=1 only on the 0 bit.
  - The next cycle returns to IDLE with s_valid=0.
- LSB-first: WIDTH=4, MSB_FIRST=0, load 4'b1110 -> S_out = 0,1,1,1.
- Stall: WIDTH=8, load 8'hA5, drop shift_en for 3 cycles after the 2nd bit.
  - S_out holds 0 for those 3 cycles.
  - The full stream is 1,0,1,0,0,1,0,1.
  - busy=1 throughout the frame.
- Back-to-back: WIDTH=4, load 4'b1001, with load_valid held high and 4'b0110 presented during the last bit.
  - Output is 8 contiguous valid bits: 1,0,0,1,0,1,1,0.
  - load_ready=1 only in the two accept cycles.
- Mid-frame reset: WIDTH=8, assert rst=0 after the 3rd bit.
  - s_valid and S_out drop to 0 asynchronously.
  - After release, load_ready=1 and a new load 8'hFF serializes cleanly.
- Parity, with PISO_PARITY_EN defined: WIDTH=4, load 4'b1110 -> S_out = 1,1,1,0,1, with s_last only on the 5th bit.
